// File: rtl/par2ser_clk8f.sv
// par2ser_clk8f: byte-to-serial transmitter in the clk8f domain.
// MSB first, idle symbol fill, forced idle preamble after reset.
module par2ser_clk8f #(
    parameter int unsigned WIDTH    = 8,
    parameter logic [7:0]  IDLE_SYM = 8'hBC,
    parameter int unsigned IDLE_PRE = 4
) (
    input  logic             clk8f,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             frame_start,
    output logic             data_active
);

    typedef enum logic {
        SYNC,
        RUN
    } state_t;

    // With no preamble the block comes out of reset ready to send data.
    localparam state_t     RST_STATE = (IDLE_PRE == 0) ? RUN : SYNC;
    localparam logic [3:0] PRE_LAST  = 4'(IDLE_PRE - 1);

    state_t     state;
    state_t     state_nx;
    logic [3:0] pre_cnt;
    logic [3:0] pre_cnt_nx;
    logic [2:0] bit_cnt;
    logic [7:0] sreg;
    logic       is_data;
    logic       load;
    logic       take;
    logic [7:0] sym;

    // Byte boundary and acceptance come only from registers.
    always_comb begin
        load      = (bit_cnt == 3'd7);
        ready_out = (state == RUN) && load;
        take      = ready_out && valid_in;
        sym       = take ? data_in : IDLE_SYM;
    end

    // Next state: count idle preamble symbols, then run forever.
    always_comb begin
        state_nx   = state;
        pre_cnt_nx = pre_cnt;
        unique case (state)
            SYNC: begin
                if (load) begin
                    pre_cnt_nx = pre_cnt + 4'd1;
                    if (pre_cnt == PRE_LAST) begin
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                state_nx = RUN;
            end
            default: begin
                state_nx = RST_STATE;
            end
        endcase
    end

    // State and preamble counter registers.
    always_ff @(posedge clk8f) begin
        if (reset) begin
            state   <= RST_STATE;
            pre_cnt <= 4'd0;
        end else begin
            state   <= state_nx;
            pre_cnt <= pre_cnt_nx;
        end
    end

    // Serializer: load a symbol every 8th cycle, shift out otherwise.
    always_ff @(posedge clk8f) begin
        if (reset) begin
            bit_cnt     <= 3'd7;
            sreg        <= 8'd0;
            data_out    <= 1'b0;
            frame_start <= 1'b0;
            is_data     <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (load) begin
                data_out    <= sym[7];
                sreg        <= {sym[6:0], 1'b0};
                frame_start <= 1'b1;
                is_data     <= take;
            end else begin
                data_out    <= sreg[7];
                sreg        <= {sreg[6:0], 1'b0};
                frame_start <= 1'b0;
            end
        end
    end

    assign data_active = is_data;

endmodule

// File: doc/par2ser_clk8f.md
# par2ser_clk8f

Parallel-to-serial transmitter that consumes bytes from the parallel data path and emits one bit per `clk8f` cycle, MSB first, onto the serial lane. It sits downstream of the clock generator and runs directly in the `clk8f` domain. Byte boundaries are derived internally from a 3-bit bit counter, so the block needs no divided clocks. When no byte is offered it sends the idle symbol. After every reset it sends a programmable preamble of idle symbols before it accepts data, so the receiver can align.

## Interface
- `WIDTH`, 8: symbol width in bits. Only 8 is supported.
- `IDLE_SYM`, 8'hBC: symbol transmitted when no data is accepted.
- `IDLE_PRE`, 4: number of forced idle symbols after reset. Range 0..15.

- `clk8f`  in  1: serial bit clock. All logic is on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `data_in`  in  8: byte offered by upstream.
- `valid_in`  in  1: `data_in` is valid.
- `ready_out`  out  1: the block accepts `data_in` on this edge if `valid_in`=1.
- `data_out`  out  1: serial bit, registered.
- `frame_start`  out  1: high while `data_out` carries bit 7 (MSB) of any symbol.
- `data_active`  out  1: high for all 8 bit-cycles of an accepted data byte; low during idle symbols.

## Operation
- **Internal registers:**
  - `bit_cnt`[2:0]: bit counter.
  - `sreg`[7:0]: shift register.
  - `pre_cnt`[3:0]: preamble counter.
  - `state`: one of {SYNC, RUN}.
  - `is_data`: data/idle flag for the current symbol.
- **Load cycle:** any cycle with `bit_cnt`==7. `bit_cnt` increments every cycle and wraps 7→0.
- **ready_out:** (`state`==RUN) && (`bit_cnt`==7). It depends only on registers and has no combinational path from `valid_in`.
- **On a load edge:**
  - Next symbol S = `data_in` if (`ready_out` && `valid_in`), else `IDLE_SYM`.
  - `data_out` <= S[7]; `sreg` <= {S[6:0],1'b0}; `frame_start` <= 1; `is_data`/`data_active` <= (S came from `data_in`).
- **On a non-load edge:** `data_out` <= `sreg`[7]; `sreg` <= `sreg`<<1; `frame_start` <= 0; `data_active` holds.
- **State SYNC:**
  - `ready_out`=0 and `valid_in` is ignored.
  - Each load edge increments `pre_cnt`.
  - On the load edge where `pre_cnt`==`IDLE_PRE`-1, the block transitions to RUN.
  - With `IDLE_PRE`=0, reset enters RUN directly.
- **State RUN:** the block stays in RUN until reset. A byte is accepted only on an edge where `ready_out`=1 and `valid_in`=1. If `valid_in`=0 there, `IDLE_SYM` is sent and nothing is consumed.
- **valid_in outside load cycles:** no effect. Upstream holds `data_in`/`valid_in` until it sees `ready_out`.
- **Reset values** (applied on any edge with `reset`=1):
  - `data_out`=0, `frame_start`=0, `data_active`=0.
  - `bit_cnt`=7, `sreg`=0, `pre_cnt`=0.
  - `state`=SYNC (or RUN if `IDLE_PRE`=0).
- **Reset mid-symbol:** the current symbol is aborted. Outputs read 0 in the cycle after the reset edge, and no partial byte is resumed.

## Timing
- Cycle 0 is the first cycle with `reset`=0. Cycle 0 is a load cycle, so load cycles fall at 0, 8, 16, …
- A symbol loaded on the cycle-c edge appears on `data_out` during cycles c+1 … c+8, MSB first. `frame_start`=1 at c+1.
- With `IDLE_PRE`=4:
  - Loads at cycles 0, 8, 16, 24 are forced idle.
  - `ready_out` first goes high at cycle 32.
  - A byte accepted at cycle 32 is on the line during cycles 33–40.
- Throughput is at most 1 byte per 8 cycles. Back-to-back bytes produce no gap bits.
- Latency from acceptance to MSB on `data_out` is 1 cycle. To LSB it is 8 cycles.
- `reset` asserted together with a load edge: reset wins. The byte is not accepted.

## Test plan
- **Reset/preamble:** hold `reset` 3 cycles, then release with `valid_in`=1, `data_in`=8'hA5.
  - `data_out` = 1011_1100 repeated 4× over cycles 1–32.
  - `ready_out`=0 until cycle 32.
  - `frame_start` pulses at 1, 9, 17, 25.
- **Single byte:** 8'hA5 offered at cycle 32 → `data_out` 1,0,1,0,0,1,0,1 in cycles 33–40; `data_active`=1 for those 8 cycles; idle 8'hBC from cycle 41.
- **Back-to-back:** 8'h00, 8'hFF, 8'h3C with `valid_in` held high → 24 contiguous bits 0×8, 1×8, 0011_1100, with no idle between symbols and `ready_out` pulsing at cycles 32, 40, 48.
- **Gap:** `valid_in`=0 at the cycle-40 load → 8'hBC sent with `data_active`=0; a byte offered at cycle 48 is accepted and sent in cycles 49–56.
- **Mid-symbol reset:** assert `reset` at cycle 36 during 8'hA5 → `data_out`, `frame_start`, and `data_active` read 0 after that edge. After release, the full 4-symbol preamble repeats before `ready_out` rises.
- **IDLE_PRE=0 build:** `ready_out`=1 at cycle 0; 8'h81 offered there → `data_out` 1,0,0,0,0,0,0,1 in cycles 1–8.
